teclado_matricial: RTL and testbench
====================================

# teclado_matricial

Keypad front-end of the lock: scans a 4x3 phone-style key matrix, synchronises and debounces presses, and accumulates accepted keys into a 20-digit shift buffer. Drives `digitos_value`/`digitos_valid` directly into the operational block. On each accepted key it emits a one-cycle valid pulse; on inactivity timeout it emits the all-`E` packet.

## Interface
- `SCAN_CYC`, 4: cycles each row is driven; range ≥3.
- `DEBOUNCE_CYC`, 20: stable cycles required for both press and release (20 ms at 1 kHz).
- `TIMEOUT_CYC`, 5000: idle cycles after the last accepted key before the timeout packet (5 s at 1 kHz).
- `clk` in 1: system clock, 1 kHz nominal.
- `rst` in 1: synchronous, active-high reset.
- `teclado_en` in 1: enable from the operational block.
- `col_matriz` in 3: column inputs; pulled up, so a pressed key reads 0. Asynchronous.
- `lin_matriz` out 4: row drives, active-low, one-hot-zero.
- `digitos_value` out senhaPac_t (20×4): digit buffer; nibble 0 holds the newest digit.
- `digitos_valid` out 1: one-cycle qualifier for `digitos_value`.

## Operation
- **Key map**
  - Row0 = 1 2 3; row1 = 4 5 6; row2 = 7 8 9; row3 = `*` 0 `#`.
  - `*` → 0xA; `#` → 0xB.
  - Empty nibble = 0xF; timeout nibble = 0xE.
- **Column synchroniser:** `col_matriz` passes through a 2-FF synchroniser (`col_s`) before any use.
- **FSM states:** SCAN, DEBOUNCE, ACCEPT, RELEASE.
- **SCAN**
  - Rows are driven in order 0→3→0, each for `SCAN_CYC` cycles.
  - `col_s` is sampled only in the last cycle of each slot.
  - Exactly one column low → latch row/col, go to DEBOUNCE, freeze the row.
  - Zero or ≥2 columns low → advance to the next row.
- **DEBOUNCE**
  - The row is held and `col_s` is compared to the latched pattern each cycle.
  - Mismatch → SCAN; the row pointer advances.
  - `DEBOUNCE_CYC` consecutive matches → ACCEPT.
- **ACCEPT (1 cycle)**
  - Buffer ← `{buffer[18:0], code}`; the oldest digit is dropped when full.
  - `digitos_valid`=1, and `digitos_value` shows the new buffer.
  - The timeout counter clears. Then → RELEASE.
- **RELEASE**
  - The row is held until `col_s`==3'b111 for `DEBOUNCE_CYC` consecutive cycles; any low sample restarts the count.
  - Then → SCAN at the next row.
  - Key held indefinitely → no repeat emission.
- **Terminator clear:** after an ACCEPT of 0xA or 0xB, the buffer becomes all-F on the next cycle.
- **Timeout**
  - The counter runs only while the buffer ≠ all-F and the FSM is not in ACCEPT.
  - On reaching `TIMEOUT_CYC`, for one cycle: `digitos_value` = 20×0xE and `digitos_valid`=1.
  - Next cycle: buffer all-F, counter 0.
  - FSM state is unaffected.
- **Simultaneous events:** if ACCEPT and timeout expiry fall on the same cycle, ACCEPT wins and the counter clears; no timeout packet is emitted.
- **Disable:** `teclado_en`=0 behaves like reset, except that it is sampled each cycle:
  - `lin_matriz`=4'b1111, FSM → SCAN at row0, buffer all-F, counters 0, `digitos_valid`=0.
- **Idle output:** `digitos_value` always reflects the buffer, except in the timeout-pulse cycle.

## Timing
- **Reset values:**
  - `lin_matriz`=4'b1111; `digitos_value`=all-F; `digitos_valid`=0.
  - FSM=SCAN with row0 pointer; the synchroniser is reset to 3'b111.
- **First cycle after reset or enable:** `lin_matriz`=4'b1110.
- **Registered outputs:** all outputs are registered; `digitos_valid` is never high on two consecutive cycles.
- **Press latency:** let d be the sample cycle in which SCAN sees the single low column. Then:
  - DEBOUNCE occupies d+1 … d+`DEBOUNCE_CYC`.
  - `digitos_valid` is high in cycle d+`DEBOUNCE_CYC`+1.
- **Raw-to-sample delay:** the raw column must be low ≥3 cycles before the slot end for sample cycle d to see it.
- **Timeout latency:** the pulse occurs exactly `TIMEOUT_CYC` cycles after the last ACCEPT cycle (counter counts 1..`TIMEOUT_CYC`).
- **Mid-operation reset/disable:** any in-progress debounce or held key is discarded; no pulse is emitted.
  - A key still held after re-enable is detected as a new press.

## Test plan
Parameters for all scenarios: `SCAN_CYC`=4, `DEBOUNCE_CYC`=4, `TIMEOUT_CYC`=50.

1. **Reset:** reset for 3 cycles → `lin_matriz`=4'b1111, `digitos_value`=all-F, `digitos_valid`=0. Then with `teclado_en`=1 → row sequence 1110, 1101, 1011, 0111, with each row held 4 cycles.
2. **Digit sequence:** press 1,2,3,4 in turn (each held 10 cycles, released 10 cycles) → four single-cycle pulses. The last pulse has nibbles[3:0] = 1,2,3,4 with 4 as newest, and nibbles above = F.
3. **Terminator:** press 5 then `#` → the pulse carries {…F,5,B}. The next cycle, `digitos_value` = all-F.
4. **Timeout:**
   - Press 7 and wait 49 cycles → no pulse. At cycle 50 → pulse with 20×E, then buffer all-F.
   - With an empty buffer and no key for 200 cycles → no pulse.
5. **Bounce rejection:** toggle a column low 2 cycles / high 1 cycle repeatedly → no pulse. Hold low 100 cycles → exactly one pulse. Two columns low together → no pulse.
6. **Overflow and disable:**
   - 21 digit presses → the oldest digit is dropped; nibble 19 holds the 2nd press.
   - Deassert `teclado_en` mid-debounce → no pulse, buffer all-F, `lin_matriz`=4'b1111.

Source files
------------

// File: rtl/teclado_matricial_if.sv
// Keypad-to-operational-block link: enable in, digit packet and its one-cycle qualifier out.
interface teclado_matricial_if;
  logic             teclado_en;
  logic [19:0][3:0] digitos_value;
  logic             digitos_valid;

  modport master (output teclado_en, input digitos_value, input digitos_valid);
  modport slave  (input teclado_en, output digitos_value, output digitos_valid);
endinterface

// File: rtl/teclado_matricial.sv
// 4x3 keypad scanner with debounce, 20-digit shift buffer and inactivity timeout.
//   state    | meaning
//   SCAN     | rotate active-low row drive, sample columns on the last cycle of each slot
//   DEBOUNCE | row frozen, column pattern must stay equal to the latched one
//   ACCEPT   | one cycle: new digit shifted in, valid pulse visible on the outputs
//   RELEASE  | row frozen until all columns read high for the debounce window
module teclado_matricial #(
  parameter int SCAN_CYC     = 4,
  parameter int DEBOUNCE_CYC = 20,
  parameter int TIMEOUT_CYC  = 5000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           col_matriz,
  output logic [3:0]           lin_matriz,
  teclado_matricial_if.slave   bus
);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, ACCEPT, RELEASE} state_t;

  localparam int CNT_MAX = (SCAN_CYC > DEBOUNCE_CYC) ? SCAN_CYC : DEBOUNCE_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int TMO_W   = $clog2(TIMEOUT_CYC + 1);

  localparam logic [CNT_W-1:0] SCAN_LOAD = CNT_W'(SCAN_CYC - 1);
  localparam logic [CNT_W-1:0] DEB_LOAD  = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [TMO_W-1:0] TMO_LOAD  = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [19:0][3:0] ALL_F     = '1;
  localparam logic [19:0][3:0] ALL_E     = {20{4'hE}};

  logic [2:0]       col_meta, col_s;
  state_t           state_q, state_n;
  logic [1:0]       row_q, row_n;
  logic [3:0]       lin_q, lin_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [2:0]       col_lat_q, col_lat_n;
  logic [19:0][3:0] buf_q, buf_n;
  logic [TMO_W-1:0] tmo_q, tmo_n;
  logic             valid_q, valid_n;
  logic [19:0][3:0] value_q, value_n;

  logic             single_low, accept, advance, term_clear, counting, expire;
  logic [1:0]       key_idx;
  logic [3:0]       key_code;

  function automatic logic [3:0] row_drive(input logic [1:0] r);
    row_drive = ~(4'b0001 << r);
  endfunction

  assign single_low = (col_s == 3'b110) || (col_s == 3'b101) || (col_s == 3'b011);

  always_comb begin
    key_idx  = 2'd2;
    key_code = 4'h0;
    case (col_lat_q)
      3'b110:  key_idx = 2'd0;
      3'b101:  key_idx = 2'd1;
      default: key_idx = 2'd2;
    endcase
    if (row_q == 2'd3) begin
      case (key_idx)
        2'd0:    key_code = 4'hA;
        2'd1:    key_code = 4'h0;
        default: key_code = 4'hB;
      endcase
    end else begin
      key_code = {2'b00, row_q} * 4'd3 + {2'b00, key_idx} + 4'd1;
    end
  end

  always_comb begin
    state_n    = state_q;
    row_n      = row_q;
    lin_n      = lin_q;
    cnt_n      = cnt_q;
    col_lat_n  = col_lat_q;
    accept     = 1'b0;
    advance    = 1'b0;
    term_clear = 1'b0;
    unique case (state_q)
      SCAN: begin
        if (lin_q == 4'hF) begin
          lin_n = row_drive(row_q);
          cnt_n = SCAN_LOAD;
        end else if (cnt_q == '0) begin
          if (single_low) begin
            state_n   = DEBOUNCE;
            col_lat_n = col_s;
            cnt_n     = DEB_LOAD;
          end else begin
            advance = 1'b1;
          end
        end else begin
          cnt_n = cnt_q - CNT_W'(1);
        end
      end
      DEBOUNCE: begin
        if (col_s != col_lat_q) begin
          advance = 1'b1;
        end else if (cnt_q == '0) begin
          // Hold one extra cycle behind a timeout pulse so valid never repeats back to back.
          if (!valid_q) begin
            state_n = ACCEPT;
            accept  = 1'b1;
          end
        end else begin
          cnt_n = cnt_q - CNT_W'(1);
        end
      end
      ACCEPT: begin
        state_n    = RELEASE;
        cnt_n      = DEB_LOAD;
        term_clear = (buf_q[0] == 4'hA) || (buf_q[0] == 4'hB);
      end
      RELEASE: begin
        if (col_s != 3'b111) begin
          cnt_n = DEB_LOAD;
        end else if (cnt_q == '0) begin
          advance = 1'b1;
        end else begin
          cnt_n = cnt_q - CNT_W'(1);
        end
      end
      default: state_n = SCAN;
    endcase
    if (advance) begin
      state_n = SCAN;
      row_n   = row_q + 2'd1;
      lin_n   = row_drive(row_q + 2'd1);
      cnt_n   = SCAN_LOAD;
    end
  end

  always_comb begin
    buf_n    = buf_q;
    tmo_n    = tmo_q;
    valid_n  = 1'b0;
    expire   = 1'b0;
    counting = (buf_q != ALL_F) && (state_q != ACCEPT);
    // Accept has priority over an expiring timeout in the same cycle.
    if (accept) begin
      buf_n   = {buf_q[18:0], key_code};
      tmo_n   = TMO_LOAD;
      valid_n = 1'b1;
    end else if (term_clear) begin
      buf_n = ALL_F;
      tmo_n = '0;
    end else if (counting && (tmo_q != '0)) begin
      if (tmo_q == TMO_W'(1)) begin
        expire  = 1'b1;
        buf_n   = ALL_F;
        tmo_n   = '0;
        valid_n = 1'b1;
      end else begin
        tmo_n = tmo_q - TMO_W'(1);
      end
    end
    value_n = expire ? ALL_E : buf_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_meta <= 3'b111;
      col_s    <= 3'b111;
    end else begin
      col_meta <= col_matriz;
      col_s    <= col_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !bus.teclado_en) begin
      state_q   <= SCAN;
      row_q     <= 2'd0;
      lin_q     <= 4'hF;
      cnt_q     <= '0;
      col_lat_q <= 3'b111;
      buf_q     <= ALL_F;
      tmo_q     <= '0;
      valid_q   <= 1'b0;
      value_q   <= ALL_F;
    end else begin
      state_q   <= state_n;
      row_q     <= row_n;
      lin_q     <= lin_n;
      cnt_q     <= cnt_n;
      col_lat_q <= col_lat_n;
      buf_q     <= buf_n;
      tmo_q     <= tmo_n;
      valid_q   <= valid_n;
      value_q   <= value_n;
    end
  end

  assign lin_matriz        = lin_q;
  assign bus.digitos_value = value_q;
  assign bus.digitos_valid = valid_q;

endmodule

// File: tb/tb_teclado_matricial.sv
// Scoreboard bench for the keypad scanner: a key-matrix model drives columns from the row drive.
module tb_teclado_matricial;
  localparam int SCAN = 4;
  localparam int DEB  = 4;
  localparam int TMO  = 50;
  localparam logic [79:0] ALL_F = '1;
  localparam logic [79:0] ALL_E = {20{4'hE}};

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  col_matriz;
  logic [3:0]  lin_matriz;
  logic [11:0] key_mask;

  teclado_matricial_if bus();

  teclado_matricial #(.SCAN_CYC(SCAN), .DEBOUNCE_CYC(DEB), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .col_matriz(col_matriz), .lin_matriz(lin_matriz), .bus(bus)
  );

  always #5 clk = ~clk;

  always_comb begin
    col_matriz = 3'b111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (!lin_matriz[r] && key_mask[r*3+c]) col_matriz[c] = 1'b0;
  end

  int pass_cnt = 0;
  int chk_cnt = 0;
  int pulse_cnt = 0;
  int cyc = 0;
  int last_valid_cyc = -1;
  logic [79:0] last_value;
  logic [79:0] exp_buf;
  logic [79:0] sb_q[$];
  bit prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [79:0] exp_pkt;
    if (bus.digitos_valid === 1'b1) begin
      pulse_cnt++;
      last_valid_cyc = cyc;
      last_value = bus.digitos_value;
      chk_cnt++;
      if (sb_q.size() == 0) begin
        $display("FAIL unexpected_pulse cyc=%0d got=%h expected no pulse", cyc, bus.digitos_value);
      end else begin
        exp_pkt = sb_q.pop_front();
        if (bus.digitos_value !== exp_pkt)
          $display("FAIL packet cyc=%0d got=%h expected=%h", cyc, bus.digitos_value, exp_pkt);
        else pass_cnt++;
      end
      chk_cnt++;
      if (prev_valid) $display("FAIL valid_back_to_back cyc=%0d got two consecutive pulses", cyc);
      else pass_cnt++;
    end
    prev_valid = (bus.digitos_valid === 1'b1);
  end

  function automatic logic [3:0] key_code(input int r, input int c);
    if (r == 3) begin
      case (c)
        0:       return 4'hA;
        1:       return 4'h0;
        default: return 4'hB;
      endcase
    end
    return 4'(r * 3 + c + 1);
  endfunction

  task automatic wait_row_start(input int r);
    logic [3:0] target, prev;
    bit found;
    target = ~(4'b0001 << r);
    prev = lin_matriz;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (lin_matriz == target && prev != target) found = 1'b1;
      else prev = lin_matriz;
    end
    if (!found) begin
      chk_cnt++;
      $display("FAIL row_start_timeout row=%0d lin=%b expected=%b", r, lin_matriz, target);
    end
  endtask

  task automatic clear_dut();
    bus.teclado_en = 1'b0;
    repeat (2) @(negedge clk);
    bus.teclado_en = 1'b1;
    exp_buf = ALL_F;
  endtask

  task automatic press_key(input int r, input int c, input int hold, input int rel,
                           input bit exp_acc, input bit chk_clear);
    int t0;
    wait_row_start(r);
    t0 = cyc;
    if (exp_acc) begin
      exp_buf = {exp_buf[75:0], key_code(r, c)};
      sb_q.push_back(exp_buf);
    end
    key_mask[r*3+c] = 1'b1;
    for (int i = 1; i <= hold; i++) begin
      @(negedge clk);
      if (chk_clear && i == 9) begin
        chk_cnt++;
        if (bus.digitos_value !== ALL_F)
          $display("FAIL terminator_clear got=%h expected=%h", bus.digitos_value, ALL_F);
        else pass_cnt++;
      end
    end
    key_mask = '0;
    if (exp_acc) begin
      chk_cnt++;
      if (last_valid_cyc != t0 + 2 + SCAN - 2 + DEB)
        $display("FAIL press_latency key=%0d%0d got_cyc=%0d expected_cyc=%0d", r, c, last_valid_cyc, t0 + SCAN + DEB);
      else pass_cnt++;
    end
    if (chk_clear) exp_buf = ALL_F;
    repeat (rel) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [3:0] exp_lin;
    rst = 1'b1;
    bus.teclado_en = 1'b1;
    key_mask = '0;
    exp_buf = ALL_F;
    repeat (3) @(negedge clk);
    chk_cnt++;
    if (lin_matriz !== 4'hF) $display("FAIL reset_lin got=%b expected=1111", lin_matriz);
    else pass_cnt++;
    chk_cnt++;
    if (bus.digitos_value !== ALL_F) $display("FAIL reset_value got=%h expected=%h", bus.digitos_value, ALL_F);
    else pass_cnt++;
    chk_cnt++;
    if (bus.digitos_valid !== 1'b0) $display("FAIL reset_valid got=%b expected=0", bus.digitos_valid);
    else pass_cnt++;
    rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      exp_lin = ~(4'b0001 << (k / SCAN));
      chk_cnt++;
      if (lin_matriz !== exp_lin) $display("FAIL row_sequence k=%0d got=%b expected=%b", k, lin_matriz, exp_lin);
      else pass_cnt++;
    end
  endtask

  task automatic test_digits();
    int p0;
    clear_dut();
    p0 = pulse_cnt;
    press_key(0, 0, 10, 10, 1'b1, 1'b0);
    press_key(0, 1, 10, 10, 1'b1, 1'b0);
    press_key(0, 2, 10, 10, 1'b1, 1'b0);
    press_key(1, 0, 10, 10, 1'b1, 1'b0);
    chk_cnt++;
    if (pulse_cnt - p0 != 4) $display("FAIL digit_pulse_count got=%0d expected=4", pulse_cnt - p0);
    else pass_cnt++;
    chk_cnt++;
    if (last_value !== {{16{4'hF}}, 16'h1234})
      $display("FAIL digit_last_packet got=%h expected=%h", last_value, {{16{4'hF}}, 16'h1234});
    else pass_cnt++;
  endtask

  task automatic test_terminator();
    clear_dut();
    press_key(1, 1, 10, 10, 1'b1, 1'b0);
    press_key(3, 2, 10, 10, 1'b1, 1'b1);
    chk_cnt++;
    if (last_value !== {{18{4'hF}}, 8'h5B})
      $display("FAIL terminator_packet got=%h expected=%h", last_value, {{18{4'hF}}, 8'h5B});
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    int a, p0;
    clear_dut();
    press_key(2, 0, 10, 10, 1'b1, 1'b0);
    a = last_valid_cyc;
    p0 = pulse_cnt;
    for (int i = 0; i < 200 && cyc < a + TMO - 1; i++) @(negedge clk);
    chk_cnt++;
    if (pulse_cnt != p0) $display("FAIL timeout_early got=%0d pulses expected=0", pulse_cnt - p0);
    else pass_cnt++;
    sb_q.push_back(ALL_E);
    exp_buf = ALL_F;
    @(negedge clk);
    #1;
    chk_cnt++;
    if (last_valid_cyc != a + TMO)
      $display("FAIL timeout_latency got_cyc=%0d expected_cyc=%0d", last_valid_cyc, a + TMO);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (bus.digitos_value !== ALL_F) $display("FAIL timeout_clear got=%h expected=%h", bus.digitos_value, ALL_F);
    else pass_cnt++;
    p0 = pulse_cnt;
    repeat (200) @(negedge clk);
    chk_cnt++;
    if (pulse_cnt != p0) $display("FAIL idle_no_timeout got=%0d pulses expected=0", pulse_cnt - p0);
    else pass_cnt++;
  endtask

  task automatic test_bounce();
    int p0;
    clear_dut();
    p0 = pulse_cnt;
    key_mask[3] = 1'b1;
    key_mask[5] = 1'b1;
    repeat (40) @(negedge clk);
    key_mask = '0;
    repeat (10) @(negedge clk);
    chk_cnt++;
    if (pulse_cnt != p0) $display("FAIL two_columns got=%0d pulses expected=0", pulse_cnt - p0);
    else pass_cnt++;
    for (int i = 0; i < 20; i++) begin
      key_mask[7] = 1'b1;
      repeat (2) @(negedge clk);
      key_mask[7] = 1'b0;
      @(negedge clk);
    end
    repeat (10) @(negedge clk);
    chk_cnt++;
    if (pulse_cnt != p0) $display("FAIL bounce_reject got=%0d pulses expected=0", pulse_cnt - p0);
    else pass_cnt++;
    exp_buf = {exp_buf[75:0], key_code(2, 1)};
    sb_q.push_back(exp_buf);
    sb_q.push_back(ALL_E);
    exp_buf = ALL_F;
    key_mask[7] = 1'b1;
    repeat (100) @(negedge clk);
    key_mask = '0;
    repeat (20) @(negedge clk);
    chk_cnt++;
    if (pulse_cnt - p0 != 2) $display("FAIL long_hold got=%0d pulses expected=2 (key then timeout)", pulse_cnt - p0);
    else pass_cnt++;
  endtask

  task automatic test_overflow_disable();
    int p0, k;
    clear_dut();
    for (int i = 0; i < 21; i++) begin
      k = i % 9;
      press_key(k / 3, k % 3, 10, 10, 1'b1, 1'b0);
    end
    chk_cnt++;
    if (last_value[79:76] !== 4'h2) $display("FAIL overflow_nibble19 got=%h expected=2", last_value[79:76]);
    else pass_cnt++;
    p0 = pulse_cnt;
    wait_row_start(1);
    key_mask[3] = 1'b1;
    repeat (6) @(negedge clk);
    bus.teclado_en = 1'b0;
    repeat (3) @(negedge clk);
    chk_cnt++;
    if (lin_matriz !== 4'hF) $display("FAIL disable_lin got=%b expected=1111", lin_matriz);
    else pass_cnt++;
    chk_cnt++;
    if (bus.digitos_value !== ALL_F) $display("FAIL disable_value got=%h expected=%h", bus.digitos_value, ALL_F);
    else pass_cnt++;
    chk_cnt++;
    if (pulse_cnt != p0) $display("FAIL disable_no_pulse got=%0d pulses expected=0", pulse_cnt - p0);
    else pass_cnt++;
    exp_buf = {ALL_F[75:0], key_code(1, 0)};
    sb_q.push_back(exp_buf);
    bus.teclado_en = 1'b1;
    repeat (30) @(negedge clk);
    chk_cnt++;
    if (pulse_cnt - p0 != 1) $display("FAIL held_after_enable got=%0d pulses expected=1", pulse_cnt - p0);
    else pass_cnt++;
    key_mask = '0;
    repeat (10) @(negedge clk);
    clear_dut();
  endtask

  initial begin
    test_reset();
    test_digits();
    test_terminator();
    test_timeout();
    test_bounce();
    test_overflow_disable();
    repeat (5) @(negedge clk);
    chk_cnt++;
    if (sb_q.size() != 0) $display("FAIL scoreboard_drain got=%0d pending expected=0", sb_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
